// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU writeback path.
// OVF_TRAP_EN adds a per-entry arith_ovf bit to wb_entry_t.
package alu_pkg;

   localparam int unsigned DATA_W     = 16;
   localparam int unsigned REG_ADDR_W = 3;

   localparam logic [3:0] COP_ZERO = 4'b0000;
   localparam logic [3:0] COP_ADD  = 4'b0001;
   localparam logic [3:0] COP_SUB  = 4'b0010;
   localparam logic [3:0] COP_MOVB = 4'b0011;
   localparam logic [3:0] COP_EQ   = 4'b0100;
   localparam logic [3:0] COP_TEST = 4'b0110;

   typedef struct packed {
      logic [DATA_W-1:0]     data;
      logic [REG_ADDR_W-1:0] dst;
      logic                  wr_en;
      logic [3:0]            cop;
      logic                  ovf;
`ifdef OVF_TRAP_EN
      logic                  arith_ovf;
`endif
   } wb_entry_t;

   function automatic logic is_arith(input logic [3:0] cop);
      return (cop == COP_ADD) || (cop == COP_SUB);
   endfunction

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry in-order buffer of wb_entry_t with valid/ready on both sides.
// Registered outputs only: nothing on the input side reaches the head combinationally.
module wb_fifo2
   import alu_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      in_valid,
   output logic      in_ready,
   input  wb_entry_t in_entry,
   output logic      out_valid,
   input  logic      out_ready,
   output wb_entry_t head
);

   wb_entry_t  mem_q [2];
   wb_entry_t  mem_d [2];
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [1:0] count_q, count_d;
   logic       push, pop;

   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign head      = mem_q[rd_ptr_q];
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = in_entry;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: 2-entry buffer to the register-file port plus overflow flag/counter.
// DATA_W/REG_ADDR_W come from alu_pkg; define OVF_TRAP_EN to suppress writes of overflowed results.
module alu_wb_stage
   import alu_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_result,
   input  logic                  in_ovf,
   input  logic [3:0]            in_cop,
   input  logic [REG_ADDR_W-1:0] in_dst,
   input  logic                  in_wr_en,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     wb_data,
   output logic [REG_ADDR_W-1:0] wb_addr,
   output logic                  wb_en,
   output logic                  ovf_sticky,
   output logic [CNT_W-1:0]      ovf_count,
   input  logic                  ovf_clr,
   output logic                  ovf_trap
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   wb_entry_t        in_entry, head;
   logic             ovf_event;
   logic             ovf_sticky_q, ovf_sticky_d;
   logic [CNT_W-1:0] ovf_count_q, ovf_count_d;
   logic             unused_head;

   assign ovf_event = in_valid & in_ready & in_ovf & is_arith(in_cop);

   always_comb begin
      in_entry       = '0;
      in_entry.data  = in_result;
      in_entry.dst   = in_dst;
      in_entry.wr_en = in_wr_en;
      in_entry.cop   = in_cop;
      in_entry.ovf   = in_ovf;
`ifdef OVF_TRAP_EN
      in_entry.arith_ovf = in_ovf & is_arith(in_cop);
`endif
   end

   wb_fifo2 u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_entry  (in_entry),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .head      (head)
   );

   assign wb_data = head.data;
   assign wb_addr = head.dst;
   // cop/ovf travel with the entry for downstream debug but are not consumed here
   assign unused_head = ^{head.cop, head.ovf};

`ifdef OVF_TRAP_EN
   assign wb_en    = out_valid & head.wr_en & ~head.arith_ovf;
   assign ovf_trap = out_valid & head.arith_ovf;
`else
   assign wb_en    = out_valid & head.wr_en;
   assign ovf_trap = 1'b0;
`endif

   // a new event wins over a same-cycle clear, so clear+event leaves exactly one
   always_comb begin
      ovf_sticky_d = ovf_sticky_q;
      ovf_count_d  = ovf_count_q;
      if (ovf_clr) begin
         ovf_sticky_d = ovf_event;
         ovf_count_d  = ovf_event ? CNT_ONE : '0;
      end else if (ovf_event) begin
         ovf_sticky_d = 1'b1;
         if (ovf_count_q != '1) ovf_count_d = ovf_count_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_sticky_q <= 1'b0;
         ovf_count_q  <= '0;
      end else begin
         ovf_sticky_q <= ovf_sticky_d;
         ovf_count_q  <= ovf_count_d;
      end
   end

   assign ovf_sticky = ovf_sticky_q;
   assign ovf_count  = ovf_count_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: queue-based reference model plus directed literal checks.
// Build with or without OVF_TRAP_EN; expectations follow the macro.
module tb_alu_wb_stage;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [15:0] in_result;
   logic        in_ovf;
   logic [3:0]  in_cop;
   logic [2:0]  in_dst;
   logic        in_wr_en;
   logic        out_valid, out_ready;
   logic [15:0] wb_data;
   logic [2:0]  wb_addr;
   logic        wb_en;
   logic        ovf_sticky;
   logic [7:0]  ovf_count;
   logic        ovf_clr;
   logic        ovf_trap;

   alu_wb_stage #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_ovf(in_ovf),
      .in_cop(in_cop), .in_dst(in_dst), .in_wr_en(in_wr_en),
      .out_valid(out_valid), .out_ready(out_ready),
      .wb_data(wb_data), .wb_addr(wb_addr), .wb_en(wb_en),
      .ovf_sticky(ovf_sticky), .ovf_count(ovf_count), .ovf_clr(ovf_clr), .ovf_trap(ovf_trap)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errs   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

`ifdef OVF_TRAP_EN
   localparam bit TRAP_ON = 1'b1;
`else
   localparam bit TRAP_ON = 1'b0;
`endif

   // reference model: an in-order list of pending writes plus flag/counter integers
   typedef struct {
      logic [15:0] data;
      logic [2:0]  dst;
      logic        wr;
      logic        arith;
   } m_entry_t;

   m_entry_t    mq[$];
   m_entry_t    m_new;
   bit          m_push, m_pop, m_ev;
   bit          m_sticky;
   int          m_cnt;
   logic [15:0] dut_log[$];

   always @(negedge rst_n) begin
      mq.delete();
      m_sticky = 1'b0;
      m_cnt    = 0;
   end

   always @(posedge clk) begin
      if (rst_n) begin
         m_push = in_valid && (mq.size() < 2);
         m_pop  = (mq.size() > 0) && out_ready;
         m_ev   = m_push && in_ovf && (in_cop == 4'd1 || in_cop == 4'd2);
         if (m_pop) void'(mq.pop_front());
         if (m_push) begin
            m_new.data  = in_result;
            m_new.dst   = in_dst;
            m_new.wr    = in_wr_en;
            m_new.arith = in_ovf && (in_cop == 4'd1 || in_cop == 4'd2);
            mq.push_back(m_new);
         end
         if (ovf_clr) begin
            m_sticky = m_ev;
            m_cnt    = m_ev ? 1 : 0;
         end else if (m_ev) begin
            m_sticky = 1'b1;
            if (m_cnt < 255) m_cnt++;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("in_ready", 32'(in_ready), 32'(mq.size() < 2));
         check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
         check("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
         check("ovf_count", 32'(ovf_count), 32'(m_cnt));
         if (mq.size() != 0) begin
            check("wb_data", 32'(wb_data), 32'(mq[0].data));
            check("wb_addr", 32'(wb_addr), 32'(mq[0].dst));
            check("wb_en", 32'(wb_en), 32'(mq[0].wr && !(TRAP_ON && mq[0].arith)));
            check("ovf_trap", 32'(ovf_trap), 32'(TRAP_ON && mq[0].arith));
         end else begin
            check("wb_en_idle", 32'(wb_en), 32'd0);
            check("ovf_trap_idle", 32'(ovf_trap), 32'd0);
         end
         if (out_valid && out_ready) dut_log.push_back(wb_data);
      end
   end

   task automatic push(input logic [3:0] cop, input logic [15:0] res, input logic o,
                       input logic [2:0] d, input logic w);
      int  waited;
      bit  acc;
      waited    = 0;
      acc       = 1'b0;
      in_cop    = cop;
      in_result = res;
      in_ovf    = o;
      in_dst    = d;
      in_wr_en  = w;
      in_valid  = 1'b1;
      while (!acc && waited < 20) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         waited++;
      end
      if (!acc) check("push_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int waited;
      rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_ovf = 1'b0; in_cop = '0;
      in_dst = '0; in_wr_en = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_wb_en", 32'(wb_en), 32'd0);
      check("rst_wb_data", 32'(wb_data), 32'd0);
      check("rst_wb_addr", 32'(wb_addr), 32'd0);
      check("rst_ovf_count", 32'(ovf_count), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // single push, visible the next cycle
      out_ready = 1'b1;
      push(COP_ADD, 16'h1234, 1'b0, 3'd3, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      check("t1_out_valid", 32'(out_valid), 32'd1);
      check("t1_wb_data", 32'(wb_data), 32'h1234);
      check("t1_wb_addr", 32'(wb_addr), 32'd3);
      check("t1_wb_en", 32'(wb_en), 32'd1);
      check("t1_sticky", 32'(ovf_sticky), 32'd0);
      @(posedge clk); #1;

      // fill with out_ready low, third push stalls until drain
      out_ready = 1'b0;
      @(posedge clk); #1;
      dut_log.delete();
      push(COP_MOVB, 16'h0001, 1'b0, 3'd1, 1'b1);
      push(COP_MOVB, 16'h0002, 1'b0, 3'd2, 1'b1);
      @(negedge clk);
      check("t2_full_in_ready", 32'(in_ready), 32'd0);
      fork
         push(COP_MOVB, 16'h0003, 1'b0, 3'd3, 1'b1);
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      in_valid = 1'b0;
      waited = 0;
      while (dut_log.size() < 3 && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      check("t2_log_size", 32'(dut_log.size()), 32'd3);
      if (dut_log.size() >= 3) begin
         check("t2_order0", 32'(dut_log[0]), 32'h0001);
         check("t2_order1", 32'(dut_log[1]), 32'h0002);
         check("t2_order2", 32'(dut_log[2]), 32'h0003);
      end

      // overflow flag and counter
      push(COP_SUB, 16'hFFFF, 1'b1, 3'd1, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      check("t3_sticky", 32'(ovf_sticky), 32'd1);
      check("t3_count1", 32'(ovf_count), 32'd1);
      @(posedge clk); #1;
      push(COP_EQ, 16'h0000, 1'b1, 3'd2, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      check("t3_eq_ignored", 32'(ovf_count), 32'd1);
      @(posedge clk); #1;
      push(COP_SUB, 16'h8000, 1'b1, 3'd1, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      check("t3_count2", 32'(ovf_count), 32'd2);
      @(posedge clk); #1;
      ovf_clr = 1'b1;
      push(COP_ADD, 16'h0005, 1'b1, 3'd4, 1'b1);
      ovf_clr = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("t3_clr_evt_sticky", 32'(ovf_sticky), 32'd1);
      check("t3_clr_evt_count", 32'(ovf_count), 32'd1);
      @(posedge clk); #1;
      ovf_clr = 1'b1;
      @(posedge clk); #1;
      ovf_clr = 1'b0;
      @(negedge clk);
      check("t3_clr_sticky", 32'(ovf_sticky), 32'd0);
      check("t3_clr_count", 32'(ovf_count), 32'd0);
      @(posedge clk); #1;

      // saturation
      for (int i = 0; i < 260; i++) push(COP_ADD, 16'(i), 1'b1, 3'd4, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      check("t4_saturate", 32'(ovf_count), 32'hFF);
      @(posedge clk); #1;

      // steady push+pop at one entry, then async reset mid-stream
      for (int i = 0; i < 11; i++) push(COP_MOVB, 16'h0100 + 16'(i), 1'b0, 3'd5, 1'b1);
      @(negedge clk);
      check("t5_in_ready", 32'(in_ready), 32'd1);
      check("t5_out_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_out_valid", 32'(out_valid), 32'd0);
      check("t5_rst_sticky", 32'(ovf_sticky), 32'd0);
      check("t5_rst_count", 32'(ovf_count), 32'd0);
      check("t5_rst_wb_en", 32'(wb_en), 32'd0);
      check("t5_rst_trap", 32'(ovf_trap), 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // overflow trap behaviour
      out_ready = 1'b0;
      push(COP_ADD, 16'h0000, 1'b1, 3'd6, 1'b1);
      in_valid = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("t6_out_valid", 32'(out_valid), 32'd1);
         check("t6_wb_en", 32'(wb_en), TRAP_ON ? 32'd0 : 32'd1);
         check("t6_trap", 32'(ovf_trap), TRAP_ON ? 32'd1 : 32'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("t6_popped", 32'(out_valid), 32'd0);
      check("t6_trap_clear", 32'(ovf_trap), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
